// File: rtl/fifo_bit_reader.sv
// fifo_bit_reader: pulls single bits out of a 1-bit FIFO, one read strobe at
// a time, and packs them LSB-first into WIDTH-bit words handed to a consumer
// through a valid/ready pair. FIFO error flags drop the offending bit and are
// latched into a sticky status bit.
module fifo_bit_reader #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk_read,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic             dataout,
    input  logic             err,
    output logic             read,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        PUSH = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [WIDTH-1:0] word_q,       word_d;
    logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic             valid_q,      valid_d;
    logic             err_sticky_q, err_sticky_d;
    logic             read_q,       read_d;

    // Next-state logic: sequencing, bit capture, word hand-off and error latch.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        word_d       = word_q;
        bit_cnt_d    = bit_cnt_q;
        valid_d      = valid_q;
        err_sticky_d = err_sticky_q;

        // Consumer handshake retires the current word; a PUSH reload below
        // overrides this in the same cycle so valid stays asserted.
        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
        // Clear comes first so a coincident new error wins.
        if (clr_err) begin
            err_sticky_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // The strobe is issued in this state; data arrives next cycle
                // regardless of what fifo_empty does in the meantime.
                state_d = CAP;
            end
            CAP: begin
                if (err) begin
                    err_sticky_d = 1'b1;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (bit_cnt_q == CW'(i)) begin
                            shift_d[i] = dataout;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
                if (bit_cnt_d == CW'(WIDTH)) begin
                    state_d = PUSH;
                end else if (!fifo_empty) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH: begin
                // Hold the completed word until the output slot frees up.
                if (!valid_q || word_ready) begin
                    word_d    = shift_q;
                    valid_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered strobe: high exactly while the FSM sits in REQ.
        read_d = (state_d == REQ);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_read) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            valid_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            read_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            valid_q      <= valid_d;
            err_sticky_q <= err_sticky_d;
            read_q       <= read_d;
        end
    end

    assign read       = read_q;
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign err_sticky = err_sticky_q;
    assign bit_cnt    = bit_cnt_q;

endmodule
